// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA3-256 padder.
// Contents: rate geometry, SHA3 domain-padding bytes and the padder FSM state type.
package sha3_pkg;

  localparam int RATE_BITS     = 1088;
  localparam int RATE_BYTES    = 136;
  localparam int WORD_W        = 64;
  localparam int WORDS_PER_BLK = RATE_BITS / WORD_W;  // 17
  localparam int IDX_W         = 16;
  localparam int CNT_W         = 5;                   // holds slot numbers 0..16

  localparam logic [7:0] PAD_DS  = 8'h06;  // SHA3 domain separator plus first pad bit
  localparam logic [7:0] PAD_END = 8'h80;  // final pad bit in the last rate byte

  typedef enum logic [1:0] {
    FILL = 2'd0,
    OUT  = 2'd1,
    XPAD = 2'd2
  } padder_state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational padding of one 64-bit message word.
// Ports:
//   word_i          message word, byte k at bits [8k+7:8k]
//   bytes_i         valid byte count (0..8, already clamped)
//   last_i          word is the last of the message
//   is_final_slot_i word sits in the last slot of the rate block
//   word_o          word with unused bytes zeroed, 0x06 written after the data
//                   and 0x80 ORed into byte 7 for the final slot
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [3:0]        bytes_i,
  input  logic              last_i,
  input  logic              is_final_slot_i,
  output logic [WORD_W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (last_i) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) > bytes_i) begin
          word_o[8*k +: 8] = 8'h00;
        end else if (4'(k) == bytes_i) begin
          word_o[8*k +: 8] = PAD_DS;
        end
      end
    end
    if (is_final_slot_i) begin
      word_o[63:56] = word_o[63:56] | PAD_END;
    end
  end

endmodule

// File: rtl/sha3_256_padder.sv
// SHA3-256 padder: packs 64-bit little-endian message words into 1088-bit
// rate blocks, applying SHA3 domain padding (0x06 ... 0x80).
// Ports:
//   clk, rst1               clock (rising edge), async active-high reset
//   in_data/in_valid/in_ready/in_last/in_bytes   message word stream
//   blk_data/blk_valid/blk_ready/blk_last/blk_idx rate block stream
//   dbg_state               current FSM state, for observation only
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1; a source holds its data stable until that edge, and valid never
// depends on ready.
module sha3_256_padder
  import sha3_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst1,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [3:0]           in_bytes,
  output logic [RATE_BITS-1:0] blk_data,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic                 blk_last,
  output logic [IDX_W-1:0]     blk_idx,
  output padder_state_t        dbg_state
);

  // Padding-only block emitted when the message exactly filled the last block.
  localparam logic [RATE_BITS-1:0] XPAD_BLK = {PAD_END, {(RATE_BITS-16){1'b0}}, PAD_DS};
  localparam logic [CNT_W-1:0]     TOP_SLOT = CNT_W'(WORDS_PER_BLK - 1);

  padder_state_t                           state_q, state_d;
  logic [WORDS_PER_BLK-1:0][WORD_W-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic                                    pend_pad_q, pend_pad_d;
  logic [IDX_W-1:0]                        idx_q, idx_d;
  logic                                    last_q, last_d;

  logic [3:0]        nb;
  logic              in_fire, out_fire, at_top, full_last;
  logic [WORD_W-1:0] padded_word;

  assign nb        = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = blk_valid & blk_ready;
  assign at_top    = (cnt_q == TOP_SLOT);
  // Message ends exactly on a block boundary: padding needs a block of its own.
  assign full_last = in_last && (nb == 4'd8) && at_top;

  sha3_pad_word u_pad (
    .word_i          (in_data),
    .bytes_i         (nb),
    .last_i          (in_last),
    .is_final_slot_i (in_last && at_top && (nb != 4'd8)),
    .word_o          (padded_word)
  );

  always_ff @(posedge clk or posedge rst1) begin
    if (rst1) begin
      state_q    <= FILL;
      buf_q      <= '0;
      cnt_q      <= '0;
      pend_pad_q <= 1'b0;
      idx_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      pend_pad_q <= pend_pad_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    pend_pad_d = pend_pad_q;
    idx_d      = idx_q;
    last_d     = last_q;
    unique case (state_q)
      FILL: begin
        if (in_fire) begin
          buf_d[cnt_q] = padded_word;
          if (!in_last) begin
            if (at_top) begin
              state_d = OUT;
              last_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (full_last) begin
            pend_pad_d = 1'b1;
            state_d    = OUT;
            last_d     = 1'b0;
          end else begin
            // A full last word below the top slot pushes 0x06 into the next slot.
            if (nb == 4'd8) begin
              buf_d[cnt_q + 1'b1][7:0] = PAD_DS;
            end
            // The top slot case already got its 0x80 from the pad word.
            if (!at_top) begin
              buf_d[WORDS_PER_BLK-1][63:56] = buf_d[WORDS_PER_BLK-1][63:56] | PAD_END;
            end
            state_d = OUT;
            last_d  = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_fire) begin
          buf_d = '0;
          cnt_d = '0;
          if (pend_pad_q) begin
            state_d = XPAD;
            idx_d   = idx_q + 1'b1;
            last_d  = 1'b1;
          end else if (last_q) begin
            state_d = FILL;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            state_d = FILL;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      XPAD: begin
        if (out_fire) begin
          pend_pad_d = 1'b0;
          idx_d      = '0;
          last_d     = 1'b0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == OUT) || (state_q == XPAD);
  assign blk_data  = (state_q == XPAD) ? XPAD_BLK : buf_q;
  assign blk_last  = last_q;
  assign blk_idx   = idx_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sha3_256_padder.sv
module tb_sha3_256_padder;
  import sha3_pkg::*;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst1;
  logic [63:0]          in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [3:0]           in_bytes;
  logic [1087:0]        blk_data;
  logic                 blk_valid;
  logic                 blk_ready;
  logic                 blk_last;
  logic [15:0]          blk_idx;
  padder_state_t        dbg_state;

  always #5 clk = ~clk;

  sha3_256_padder dut (
    .clk       (clk),
    .rst1      (rst1),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .blk_idx   (blk_idx),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  byte unsigned  msg_b [0:1023];
  int            msg_len;
  int            stall_first = 0;
  logic [1087:0] exp_q      [$];
  logic          exp_last_q [$];
  logic [15:0]   exp_idx_q  [$];

  task automatic check(input string tag, input logic [1087:0] obs, input logic [1087:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: pad = msg || 0x06 || 0* || 0x80 (XORed), cut into 136-byte blocks.
  task automatic model_msg();
    byte unsigned pad [0:2047];
    int nblk;
    logic [1087:0] blk;
    nblk = msg_len / RATE_BYTES + 1;
    for (int i = 0; i < nblk * RATE_BYTES; i++) pad[i] = (i < msg_len) ? msg_b[i] : 8'h00;
    pad[msg_len]                  = pad[msg_len] ^ 8'h06;
    pad[nblk * RATE_BYTES - 1]    = pad[nblk * RATE_BYTES - 1] ^ 8'h80;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < RATE_BYTES; j++) blk[8*j +: 8] = pad[b * RATE_BYTES + j];
      exp_q.push_back(blk);
      exp_last_q.push_back(b == nblk - 1);
      exp_idx_q.push_back(16'(b));
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_msg(input bit rnd);
    int nwords, widx, cyc, hold, rem, bi;
    logic [63:0] w;
    model_msg();
    nwords = (msg_len == 0) ? 1 : (msg_len + 7) / 8;
    widx   = 0;
    cyc    = 0;
    hold   = stall_first;
    while ((widx < nwords || exp_q.size() > 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_valid  = 1'b0;
      blk_ready = 1'b0;
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_blk", 1088'(blk_valid), 1088'(0));
        end else begin
          check("blk_data", blk_data, exp_q[0]);
          check("blk_last", 1088'(blk_last), 1088'(exp_last_q[0]));
          check("blk_idx", 1088'(blk_idx), 1088'(exp_idx_q[0]));
          check("in_ready_busy", 1088'(in_ready), 1088'(0));
          if (hold > 0) begin
            hold--;
            // junk word offered while the padder is busy must be ignored
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            in_last  = 1'($urandom_range(0, 1));
            in_bytes = 4'($urandom_range(0, 15));
          end else if (!(rnd && $urandom_range(0, 2) == 0)) begin
            blk_ready = 1'b1;
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            void'(exp_idx_q.pop_front());
          end
        end
      end else if (in_ready && widx < nwords && !(rnd && $urandom_range(0, 3) == 0)) begin
        for (int k = 0; k < 8; k++) begin
          bi = widx * 8 + k;
          w[8*k +: 8] = (bi < msg_len) ? msg_b[bi] : 8'($urandom);
        end
        in_data = w;
        in_last = (widx == nwords - 1);
        rem     = msg_len - 8 * widx;
        if (in_last) in_bytes = (rem == 8) ? 4'($urandom_range(8, 15)) : 4'(rem);
        else         in_bytes = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        widx++;
      end
    end
    @(negedge clk);
    in_valid    = 1'b0;
    blk_ready   = 1'b0;
    stall_first = 0;
    if (cyc >= 4000) check("timeout", 1088'(1), 1088'(0));
    check("queue_drained", 1088'(exp_q.size()), 1088'(0));
  endtask

  task automatic drive_word(input logic [63:0] d);
    int waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) check("drive_timeout", 1088'(1), 1088'(0));
    in_valid = 1'b1;
    in_data  = d;
    in_last  = 1'b0;
    in_bytes = 4'd0;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst1 = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0; blk_ready = 1'b0;
    #12;
    check("rst_blk_valid", 1088'(blk_valid), 1088'(0));
    check("rst_blk_last", 1088'(blk_last), 1088'(0));
    check("rst_blk_idx", 1088'(blk_idx), 1088'(0));
    check("rst_blk_data", blk_data, 1088'(0));
    @(negedge clk); rst1 = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 1088'(in_ready), 1088'(1));
    check("post_rst_state", 1088'(dbg_state), 1088'(FILL));

    // empty message
    msg_len = 0;
    run_msg(1'b0);

    // "abc"
    msg_len = 3; msg_b[0] = 8'h61; msg_b[1] = 8'h62; msg_b[2] = 8'h63;
    run_msg(1'b0);

    // 135 bytes: 0x06 and 0x80 share byte 135
    msg_len = 135;
    for (int i = 0; i < msg_len; i++) msg_b[i] = 8'($urandom);
    run_msg(1'b0);

    // 136 bytes then 1 byte
    msg_len = 136;
    for (int i = 0; i < msg_len; i++) msg_b[i] = 8'($urandom);
    run_msg(1'b0);
    msg_len = 1; msg_b[0] = 8'($urandom);
    run_msg(1'b0);

    // backpressure: 5 cycles of blk_ready=0 with a junk word offered
    msg_len = 20;
    for (int i = 0; i < msg_len; i++) msg_b[i] = 8'($urandom);
    stall_first = 5;
    run_msg(1'b0);

    // reset mid-fill: one block out (idx=1), then 9 words of the next
    for (int i = 0; i < 17; i++) drive_word({$urandom, $urandom});
    check("fill_latency_valid", 1088'(blk_valid), 1088'(1));
    check("fill_blk_last", 1088'(blk_last), 1088'(0));
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive_word({$urandom, $urandom});
    check("pre_rst_idx", 1088'(blk_idx), 1088'(1));
    rst1 = 1'b1;
    #1;
    check("async_rst_state", 1088'(dbg_state), 1088'(FILL));
    check("async_rst_idx", 1088'(blk_idx), 1088'(0));
    check("async_rst_valid", 1088'(blk_valid), 1088'(0));
    check("async_rst_data", blk_data, 1088'(0));
    @(negedge clk); rst1 = 1'b0;
    @(negedge clk);

    // 2-byte message after reset
    msg_len = 2; msg_b[0] = 8'($urandom); msg_b[1] = 8'($urandom);
    run_msg(1'b0);

    // random messages with random gaps and stalls
    for (int m = 0; m < 12; m++) begin
      msg_len = $urandom_range(0, 300);
      if (m == 3) msg_len = 272;  // two full blocks plus padding block
      for (int i = 0; i < msg_len; i++) msg_b[i] = 8'($urandom);
      stall_first = $urandom_range(0, 3);
      run_msg(1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_256_padder.md
Name: sha3_256_padder

Overview:
- Upstream feeder for the SHA3-256 sponge core.
- Accepts a message as a stream of 64-bit little-endian words with valid/ready handshake.
- Applies SHA3 domain padding (0x06 … 0x80) and packs words into 1088-bit rate blocks.
- Presents each block on a valid/ready output, with a flag marking the final block of a message.

Parameters:
- RATE_BITS, 1088, sponge rate in bits (136 bytes).
- WORD_W, 64, input word width.
- WORDS_PER_BLK, 17, RATE_BITS/WORD_W; derived, not overridable.
- IDX_W, 16, width of the per-message block index counter.

Ports:
- clk  in  1  clock, rising edge.
- rst1  in  1  reset, asynchronous, active-high.
- in_data  in  64  message word; byte k at bits [8k+7:8k].
- in_valid  in  1  in_data valid.
- in_ready  out  1  padder accepts a word this cycle.
- in_last  in  1  word is the last of the message.
- in_bytes  in  4  valid bytes in the last word (0..8); ignored unless in_last.
- blk_data  out  1088  padded rate block; word i at bits [64i+63:64i].
- blk_valid  out  1  blk_data valid.
- blk_ready  in  1  downstream consumes the block.
- blk_last  out  1  block is the final (padded) block of the message.
- blk_idx  out  16  0-based index of the block within the current message.

Behaviour:
- Reset (rst1=1, asynchronous): all of the following clear immediately, and any partial block or message is discarded.
  - State goes to FILL.
  - Buffer, word counter cnt, pend_pad, blk_idx and blk_last become 0.
  - in_ready=1 and blk_valid=0 once reset deasserts.
- States: FILL, OUT, XPAD.
- in_ready = (state==FILL). blk_valid = (state==OUT or state==XPAD).
- FILL, input handshake (in_valid & in_ready):
  - Store in_data at word slot cnt, masked to in_bytes bytes when in_last. Unused bytes are forced to 0.
  - Non-last word, cnt<16: cnt++.
  - Non-last word, cnt==16: go to OUT with blk_last=0.
  - Last word with in_bytes<8, or with in_bytes==8 and cnt<16:
    - Byte position p = 8*cnt + min(in_bytes,8). Write 0x06 at p.
    - XOR 0x80 into byte 135; p==135 yields 0x86.
    - Slots above cnt stay 0. Go to OUT with blk_last=1.
  - Last word with in_bytes==8 and cnt==16: block is full. Set pend_pad=1 and go to OUT with blk_last=0.
  - in_bytes>8 is clamped to 8.
- OUT:
  - blk_data, blk_last and blk_idx are held stable while blk_valid=1 and blk_ready=0.
  - Output handshake (blk_valid & blk_ready): clear buffer and cnt.
    - If pend_pad: go to XPAD; blk_idx++.
    - Else if blk_last: go to FILL; blk_idx=0.
    - Else: go to FILL; blk_idx++.
- XPAD:
  - Output block has byte0=0x06, byte135=0x80, all other bytes 0; blk_last=1.
  - On handshake: pend_pad=0, blk_idx=0, go to FILL.
- Latency: blk_valid rises the cycle after the completing word is accepted.
- Minimum block period is 18 cycles: 17 fill cycles plus 1 output cycle. No input/output overlap (single buffer).
- blk_idx wraps modulo 2^16.
- in_valid with in_ready=0 has no effect; the upstream source must hold its data.
- A zero-length message is in_last=1, in_bytes=0 at cnt=0 → one padding-only block.

Decomposition:
- Package sha3_pkg contains:
  - RATE_BITS, RATE_BYTES=136, WORDS_PER_BLK=17.
  - PAD_DS=8'h06, PAD_END=8'h80.
  - Enum padder_state_t {FILL, OUT, XPAD}.
- One combinational sub-module, sha3_pad_word:
  - Inputs: word, in_bytes, last flag, is_final_slot.
  - Output: masked word with 0x06 inserted and 0x80 ORed into byte 7 when is_final_slot.
  - Keeps the top-level FSM and buffer under 250 lines.

Test Plan:
- Empty message: one word, in_last=1, in_bytes=0 → single block, byte0=0x06, byte135=0x80, rest 0, blk_last=1, blk_idx=0.
- 3-byte message "abc" (in_data=0x636261, in_bytes=3) → bytes 0..3 = 61 62 63 06, byte135=0x80; blk_data matches the NIST SHA3-256("abc") first-block padding.
- 135-byte message (16 full words + last with in_bytes=7) → one block, byte135=0x86, blk_last=1.
- 136-byte message (17 full words, last in_bytes=8), then a 1-byte message:
  - Block 0: message only, blk_last=0, idx=0.
  - Block 1: padding only, blk_last=1, idx=1.
  - Next message restarts at idx=0.
- Backpressure and reset:
  - Hold blk_ready=0 for 5 cycles → blk_data/blk_last/blk_idx stable, in_ready=0, no word accepted.
  - Assert rst1 mid-fill at cnt=9 → outputs clear immediately.
  - A following 2-byte message yields a correct single block.
